// File: rtl/output_accum_sequencer_pkg.sv
// Shared definitions for the output-bank read-modify-write sequencers.
package output_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCEPT    = 3'd1,
    READ      = 3'd2,
    WAIT_DATA = 3'd3,
    LATCH     = 3'd4,
    WRITE     = 3'd5,
    ADVANCE   = 3'd6,
    DONE      = 3'd7
  } seq_state_t;

  // Value of cfg_overwrite selecting each pass type.
  localparam logic MODE_ACC = 1'b0;
  localparam logic MODE_OVR = 1'b1;

endpackage

// File: rtl/output_accum_sequencer_if.sv
// Control, handshake and BRAM-side signals of the output accumulation sequencer.
interface output_accum_sequencer_if #(
  parameter int NUM_BANKS = 16,
  parameter int ADDR_W    = 10
);
  logic                 i_start;
  logic [ADDR_W-1:0]    i_cfg_base;
  logic [ADDR_W-1:0]    i_cfg_len;
  logic                 i_cfg_overwrite;
  logic [NUM_BANKS-1:0] i_cfg_lane_mask;
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic                 o_en_reg_new;
  logic [NUM_BANKS-1:0] o_rd_en;
  logic [NUM_BANKS-1:0] o_wr_en;
  logic [ADDR_W-1:0]    o_bank_addr;
  logic                 o_en_reg_adder;
  logic                 o_sel_acc;
  logic                 o_busy;
  logic                 o_done;

  // master: the controller/systolic side; slave: the sequencer itself
  modport master (
    output i_start, i_cfg_base, i_cfg_len, i_cfg_overwrite, i_cfg_lane_mask, i_in_valid,
    input  o_in_ready, o_en_reg_new, o_rd_en, o_wr_en, o_bank_addr,
    input  o_en_reg_adder, o_sel_acc, o_busy, o_done
  );

  modport slave (
    input  i_start, i_cfg_base, i_cfg_len, i_cfg_overwrite, i_cfg_lane_mask, i_in_valid,
    output o_in_ready, o_en_reg_new, o_rd_en, o_wr_en, o_bank_addr,
    output o_en_reg_adder, o_sel_acc, o_busy, o_done
  );
endinterface

// File: rtl/output_accum_sequencer_addr_counter.sv
// Loadable base/length address counter with modulo-2^ADDR_W wrap and a last-word flag.
module output_addr_counter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] w_count_inc;

  assign w_count_inc = r_count + 1'b1;
  // last is true while processing the final word, so a step now completes the run
  assign o_last      = (w_count_inc == r_len);
  assign o_addr      = r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_count <= '0;
      r_len   <= '0;
    end else if (i_load) begin
      r_addr  <= i_base;
      r_count <= '0;
      r_len   <= i_len;
    end else if (i_step) begin
      r_addr  <= r_addr + 1'b1;
      r_count <= w_count_inc;
    end
  end
endmodule

// File: rtl/output_accum_sequencer.sv
// Read-modify-write sequencer for the transpose-convolution output result banks:
// one partial-sum word per handshake, read old value, wait RD_LAT, write the sum back.
module output_accum_sequencer
  import output_seq_pkg::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output_accum_sequencer_if.slave  bus
);
  localparam int LAT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  seq_state_t           r_state;
  logic                 r_mode;
  logic [NUM_BANKS-1:0] r_mask;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic                 r_in_ready;
  logic [NUM_BANKS-1:0] r_rd_en;
  logic [NUM_BANKS-1:0] r_wr_en;
  logic                 r_en_reg_adder;
  logic                 r_sel_acc;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_load;
  logic                 w_step;
  logic                 w_last;
  logic [ADDR_W-1:0]    w_addr;

  assign w_load = (r_state == IDLE) && bus.i_start;
  assign w_step = (r_state == ADVANCE);

  output_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_base (bus.i_cfg_base),
    .i_len  (bus.i_cfg_len),
    .i_step (w_step),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  // Outputs are registered: each branch sets the values belonging to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_mode         <= MODE_ACC;
      r_mask         <= '0;
      r_lat_cnt      <= '0;
      r_in_ready     <= 1'b0;
      r_rd_en        <= '0;
      r_wr_en        <= '0;
      r_en_reg_adder <= 1'b0;
      r_sel_acc      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_in_ready     <= 1'b0;
      r_rd_en        <= '0;
      r_wr_en        <= '0;
      r_en_reg_adder <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_mode <= bus.i_cfg_overwrite;
            r_mask <= bus.i_cfg_lane_mask;
            r_busy <= 1'b1;
            if (bus.i_cfg_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ACCEPT;
              r_in_ready <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (bus.i_in_valid) begin
            if (r_mode == MODE_OVR) begin
              r_state   <= WRITE;
              r_wr_en   <= r_mask;
              r_sel_acc <= 1'b0;
            end else begin
              r_state   <= READ;
              r_rd_en   <= r_mask;
              r_sel_acc <= 1'b1;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        READ: begin
          if (RD_LAT == 1) begin
            r_state        <= LATCH;
            r_en_reg_adder <= 1'b1;
          end else begin
            r_state   <= WAIT_DATA;
            r_rd_en   <= r_mask;
            r_lat_cnt <= LAT_INIT;
          end
        end
        WAIT_DATA: begin
          if (r_lat_cnt == '0) begin
            r_state        <= LATCH;
            r_en_reg_adder <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
            r_rd_en   <= r_mask;
          end
        end
        LATCH: begin
          r_state <= WRITE;
          r_wr_en <= r_mask;
        end
        WRITE: begin
          r_state   <= ADVANCE;
          r_sel_acc <= 1'b0;
        end
        ADVANCE: begin
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= ACCEPT;
            r_in_ready <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_in_ready     = r_in_ready;
  assign bus.o_en_reg_new   = bus.i_in_valid & r_in_ready;
  assign bus.o_rd_en        = r_rd_en;
  assign bus.o_wr_en        = r_wr_en;
  assign bus.o_bank_addr    = w_addr;
  assign bus.o_en_reg_adder = r_en_reg_adder;
  assign bus.o_sel_acc      = r_sel_acc;
  assign bus.o_busy         = r_busy;
  assign bus.o_done         = r_done;
endmodule

// File: tb/tb_output_accum_sequencer.sv
// Three sequencers (RD_LAT 2, 1, 4) share one randomized stimulus; each is checked every
// cycle against a timeline model derived from the word-acceptance cycle.
module tb_output_accum_sequencer;
  localparam int NB = 16;
  localparam int AW = 10;
  localparam int JOB_BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tb_start = 1'b0;
  logic [AW-1:0] tb_base = '0;
  logic [AW-1:0] tb_len = '0;
  logic          tb_ovr = 1'b0;
  logic [NB-1:0] tb_mask = '0;
  logic          tb_in_valid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  wire [2:0] w_busy;
  wire [2:0] w_wr_any;
  wire [2:0] w_any_out;

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

    output_accum_sequencer_if #(.NUM_BANKS(NB), .ADDR_W(AW)) ifc ();

    assign ifc.i_start         = tb_start;
    assign ifc.i_cfg_base      = tb_base;
    assign ifc.i_cfg_len       = tb_len;
    assign ifc.i_cfg_overwrite = tb_ovr;
    assign ifc.i_cfg_lane_mask = tb_mask;
    assign ifc.i_in_valid      = tb_in_valid;

    output_accum_sequencer #(.NUM_BANKS(NB), .ADDR_W(AW), .RD_LAT(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );

    assign w_busy[gi]    = ifc.o_busy;
    assign w_wr_any[gi]  = |ifc.o_wr_en;
    assign w_any_out[gi] = ifc.o_in_ready | ifc.o_en_reg_new | (|ifc.o_rd_en) | (|ifc.o_wr_en) |
                           (|ifc.o_bank_addr) | ifc.o_en_reg_adder | ifc.o_sel_acc |
                           ifc.o_busy | ifc.o_done;

    // Model: a job is a list of words; word k accepted at cycle T occupies a fixed timeline.
    int            m_cyc = 0;
    int            m_acc_t = -1;
    int            m_ready_t = -1;
    int            m_done_t = -1;
    int            m_k = 0;
    bit            m_busy = 1'b0;
    bit            m_ovr = 1'b0;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_len = '0;
    logic [NB-1:0] m_mask = '0;

    initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_cyc = 0; m_acc_t = -1; m_ready_t = -1; m_done_t = -1; m_k = 0;
        m_busy = 1'b0; m_ovr = 1'b0; m_base = '0; m_len = '0; m_mask = '0;
      end else begin
        m_cyc = m_cyc + 1;
        if (!m_busy) begin
          if (tb_start) begin
            m_base = tb_base; m_len = tb_len; m_ovr = tb_ovr; m_mask = tb_mask;
            m_busy = 1'b1; m_k = 0; m_acc_t = -1;
            if (tb_len == '0) begin
              m_done_t = m_cyc; m_ready_t = -1;
            end else begin
              m_ready_t = m_cyc; m_done_t = -1;
            end
          end
        end else if (m_done_t >= 0) begin
          if (m_cyc == m_done_t + 1) begin
            m_busy = 1'b0; m_done_t = -1;
          end
        end else if (m_acc_t < 0) begin
          if (m_ready_t >= 0 && tb_in_valid) m_acc_t = m_cyc - 1;
        end else if (m_cyc == m_acc_t + (m_ovr ? 3 : 4 + LAT)) begin
          $display("[L%0d] word %0d written addr=%03h mask=%04h mode=%s", LAT, m_k,
                   m_base + AW'(m_k), m_mask, m_ovr ? "ovr" : "acc");
          m_k = m_k + 1;
          m_acc_t = -1;
          if (m_k == int'(m_len)) begin
            m_done_t = m_cyc; m_ready_t = -1;
          end else begin
            m_ready_t = m_cyc;
          end
        end
      end
    end

    initial begin
      string pfx;
      int    d;
      bit    act, e_ready, e_lat, e_sel, e_done;
      logic [NB-1:0] e_rd, e_wr;
      logic [AW-1:0] e_addr;
      pfx = $sformatf("L%0d_", LAT);
      forever begin
        @(negedge clk);
        act     = (m_acc_t >= 0);
        d       = m_cyc - m_acc_t;
        e_ready = m_busy && !act && (m_ready_t >= 0);
        e_rd    = (act && !m_ovr && d >= 1 && d <= LAT) ? m_mask : '0;
        e_lat   = act && !m_ovr && (d == LAT + 1);
        e_wr    = (act && (m_ovr ? (d == 1) : (d == LAT + 2))) ? m_mask : '0;
        e_sel   = act && !m_ovr && d >= 1 && d <= LAT + 2;
        e_done  = (m_done_t >= 0) && (m_cyc == m_done_t);
        e_addr  = m_base + AW'(m_k);
        chk_eq({pfx, "in_ready"},   32'(ifc.o_in_ready),     32'(e_ready));
        chk_eq({pfx, "en_reg_new"}, 32'(ifc.o_en_reg_new),   32'(e_ready & tb_in_valid));
        chk_eq({pfx, "rd_en"},      32'(ifc.o_rd_en),        32'(e_rd));
        chk_eq({pfx, "wr_en"},      32'(ifc.o_wr_en),        32'(e_wr));
        chk_eq({pfx, "bank_addr"},  32'(ifc.o_bank_addr),    32'(e_addr));
        chk_eq({pfx, "en_reg_add"}, 32'(ifc.o_en_reg_adder), 32'(e_lat));
        chk_eq({pfx, "sel_acc"},    32'(ifc.o_sel_acc),      32'(e_sel));
        chk_eq({pfx, "busy"},       32'(ifc.o_busy),         32'(m_busy));
        chk_eq({pfx, "done"},       32'(ifc.o_done),         32'(e_done));
      end
    end
  end

  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic ovr,
                         input logic [NB-1:0] mask, input int vmode, input bit poke);
    int n;
    @(posedge clk); #1;
    tb_start = 1'b1; tb_base = base; tb_len = len; tb_ovr = ovr; tb_mask = mask;
    tb_in_valid = (vmode == 0);
    @(posedge clk); #1;
    tb_start = 1'b0;
    tb_base = AW'($urandom); tb_len = AW'($urandom); tb_ovr = 1'($urandom); tb_mask = NB'($urandom);
    n = 0;
    while (w_busy != 3'b000 && n < JOB_BUDGET) begin
      case (vmode)
        0:       tb_in_valid = 1'b1;
        1:       tb_in_valid = ($urandom_range(0, 3) != 0);
        default: tb_in_valid = (n >= 5);
      endcase
      tb_start = poke && (n == 2);
      @(posedge clk); #1;
      n++;
    end
    tb_start = 1'b0;
    tb_in_valid = 1'b0;
    chk_eq("job_end_idle", 32'(w_busy), 32'd0);
    $display("job base=%03h len=%0d ovr=%0d mask=%04h vmode=%0d cycles=%0d",
             base, len, ovr, mask, vmode, n);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;

    run_job(10'h3FE, 10'd4, 1'b0, 16'hFFFF, 0, 1'b0);
    run_job(10'h010, 10'd3, 1'b1, 16'hFFFF, 0, 1'b0);
    run_job(10'h100, 10'd5, 1'b0, 16'h0005, 1, 1'b0);
    run_job(10'h200, 10'd3, 1'b0, 16'hFFFF, 2, 1'b0);
    run_job(10'h055, 10'd0, 1'b0, 16'hFFFF, 0, 1'b0);
    run_job(10'h300, 10'd5, 1'b0, 16'h00F0, 1, 1'b1);
    run_job(10'h020, 10'd2, 1'b0, 16'h0000, 1, 1'b0);
    for (int j = 0; j < 8; j++)
      run_job(AW'($urandom), AW'($urandom_range(0, 9)), 1'($urandom), NB'($urandom),
              $urandom_range(0, 2), 1'b0);

    // Asynchronous reset while the RD_LAT=2 instance is writing.
    @(posedge clk); #1;
    tb_start = 1'b1; tb_base = 10'h0A0; tb_len = 10'd6; tb_ovr = 1'b0; tb_mask = 16'hFFFF;
    tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_start = 1'b0;
    n = 0;
    while (w_wr_any[0] == 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_eq("rst_reached_write", 32'(w_wr_any[0]), 32'd1);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk_eq($sformatf("rst_async_outputs_%0d", i), 32'(w_any_out[i]), 32'd0);
    tb_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("post_rst_busy", 32'(w_busy), 32'd0);
    run_job(10'h3FF, 10'd3, 1'b0, 16'h8001, 1, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
